// File: rtl/ntt_pkg.sv
// Shared constants, FSM state types and index helper for the NTT input receiver.
package ntt_pkg;

  localparam int N_COEF = 128;
  localparam int N_BEAT = 16;
  localparam int COEF_W = 4;
  localparam int OUT_W  = 16;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rd_state_t;

  function automatic logic [6:0] bitrev7(input logic [6:0] v);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = v[6-i];
    return r;
  endfunction

endpackage

// File: rtl/ntt_rx_bank.sv
// One frame buffer: 16 beats of 32 bits, written per beat, read per 4-bit coefficient.
module ntt_rx_bank
  import ntt_pkg::*;
(
  input  logic              clk1,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [31:0]       wdata,
  input  logic [6:0]        ridx,
  output logic [COEF_W-1:0] rdata
);

  logic [31:0] mem [N_BEAT];
  logic [31:0] word;

  always_ff @(posedge clk1) begin
    if (we) mem[waddr] <= wdata;
  end

  assign word  = mem[ridx[6:3]];
  assign rdata = word[{ridx[2:0], 2'b00} +: COEF_W];

endmodule

// File: rtl/ntt_in_receiver.sv
// Ping-pong frame receiver: captures 16-beat input frames and replays 128 coefficients.
//   state    | meaning
//   W_IDLE   | waiting for the first beat of a frame
//   W_FILL   | storing beats 2..16 into the write bank
//   W_DROP   | discarding a frame that found no free bank
//   R_IDLE   | one-cycle gap; waiting for the read bank to be full
//   R_STREAM | presenting coefficients of the read bank downstream
module ntt_in_receiver
  import ntt_pkg::*;
#(
  parameter int BIT_REV = 0
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        coef_valid,
  input  logic        coef_ready,
  output logic [15:0] coef_data,
  output logic [6:0]  coef_idx,
  output logic        coef_last,
  output logic        frame_err,
  output logic        ovf_err
);

  localparam bit BR = (BIT_REV != 0);

  wr_state_t   wr_state, wr_state_nxt;
  logic [3:0]  wr_cnt, wr_cnt_nxt;
  logic        wr_bank, wr_bank_nxt;
  logic [1:0]  full, full_nxt, full_rel;
  logic        frame_err_nxt, ovf_err_nxt;
  logic [1:0]  bank_we;
  logic [3:0]  bank_waddr;

  rd_state_t   rd_state, rd_state_nxt;
  logic [6:0]  rd_cnt, rd_cnt_nxt;
  logic        rd_bank, rd_bank_nxt;
  logic        release_bank;
  logic        xfer;
  logic        rd_at_last;
  logic [6:0]  map_idx;
  logic [COEF_W-1:0] nib0, nib1, nib;

  assign coef_valid = (rd_state == R_STREAM);
  assign xfer       = coef_valid & coef_ready;
  assign rd_at_last = (rd_cnt == 7'(N_COEF - 1));
  assign map_idx    = BR ? bitrev7(rd_cnt) : rd_cnt;

  always_comb begin
    rd_state_nxt = rd_state;
    rd_cnt_nxt   = rd_cnt;
    rd_bank_nxt  = rd_bank;
    release_bank = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (full[rd_bank]) begin
          rd_state_nxt = R_STREAM;
          rd_cnt_nxt   = 7'd0;
        end
      end
      R_STREAM: begin
        if (xfer) begin
          rd_cnt_nxt = rd_cnt + 7'd1;
          if (rd_at_last) begin
            release_bank = 1'b1;
            rd_bank_nxt  = ~rd_bank;
            rd_state_nxt = R_IDLE;
          end
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // A bank freed by this cycle's final transfer is already available to a new frame.
  always_comb begin
    full_rel = full;
    if (release_bank) full_rel[rd_bank] = 1'b0;
  end

  always_comb begin
    wr_state_nxt  = wr_state;
    wr_cnt_nxt    = wr_cnt;
    wr_bank_nxt   = wr_bank;
    full_nxt      = full_rel;
    frame_err_nxt = 1'b0;
    ovf_err_nxt   = 1'b0;
    bank_we       = 2'b00;
    bank_waddr    = wr_cnt;
    case (wr_state)
      W_IDLE: begin
        if (in_valid) begin
          wr_cnt_nxt = 4'd1;
          if (!full_rel[wr_bank]) begin
            bank_we[wr_bank] = 1'b1;
            bank_waddr       = 4'd0;
            wr_state_nxt     = W_FILL;
          end else begin
            ovf_err_nxt  = 1'b1;
            wr_state_nxt = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (in_valid) begin
          bank_we[wr_bank] = 1'b1;
          if (wr_cnt == 4'd15) begin
            full_nxt[wr_bank] = 1'b1;
            wr_bank_nxt       = ~wr_bank;
            wr_cnt_nxt        = 4'd0;
            wr_state_nxt      = W_IDLE;
          end else begin
            wr_cnt_nxt = wr_cnt + 4'd1;
          end
        end else begin
          frame_err_nxt = 1'b1;
          wr_cnt_nxt    = 4'd0;
          wr_state_nxt  = W_IDLE;
        end
      end
      W_DROP: begin
        if (in_valid && wr_cnt != 4'd15) begin
          wr_cnt_nxt = wr_cnt + 4'd1;
        end else begin
          wr_cnt_nxt   = 4'd0;
          wr_state_nxt = W_IDLE;
        end
      end
      default: begin
        wr_cnt_nxt   = 4'd0;
        wr_state_nxt = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      wr_state  <= W_IDLE;
      wr_cnt    <= 4'd0;
      wr_bank   <= 1'b0;
      full      <= 2'b00;
      frame_err <= 1'b0;
      ovf_err   <= 1'b0;
      rd_state  <= R_IDLE;
      rd_cnt    <= 7'd0;
      rd_bank   <= 1'b0;
    end else begin
      wr_state  <= wr_state_nxt;
      wr_cnt    <= wr_cnt_nxt;
      wr_bank   <= wr_bank_nxt;
      full      <= full_nxt;
      frame_err <= frame_err_nxt;
      ovf_err   <= ovf_err_nxt;
      rd_state  <= rd_state_nxt;
      rd_cnt    <= rd_cnt_nxt;
      rd_bank   <= rd_bank_nxt;
    end
  end

  ntt_rx_bank u_bank0 (
    .clk1  (clk1),
    .we    (bank_we[0]),
    .waddr (bank_waddr),
    .wdata (in_data),
    .ridx  (map_idx),
    .rdata (nib0)
  );

  ntt_rx_bank u_bank1 (
    .clk1  (clk1),
    .we    (bank_we[1]),
    .waddr (bank_waddr),
    .wdata (in_data),
    .ridx  (map_idx),
    .rdata (nib1)
  );

  assign nib       = rd_bank ? nib1 : nib0;
  assign coef_data = coef_valid ? {{(OUT_W-COEF_W){1'b0}}, nib} : '0;
  assign coef_idx  = coef_valid ? map_idx : 7'd0;
  assign coef_last = coef_valid & rd_at_last;

endmodule

// File: tb/tb_ntt_in_receiver.sv
// Self-checking bench for ntt_in_receiver: natural-order and bit-reversed instances share stimulus.
module tb_ntt_in_receiver;

  typedef struct packed {
    logic [6:0]  idx;
    logic [15:0] data;
    logic        last;
    logic [31:0] cyc;
  } xfer_t;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        coef_ready;
  logic        coef_valid, coef_last, frame_err, ovf_err;
  logic [15:0] coef_data;
  logic [6:0]  coef_idx;
  logic        br_valid, br_last, br_ferr, br_oerr;
  logic [15:0] br_data;
  logic [6:0]  br_idx;

  int checks = 0;
  int errors = 0;
  logic [31:0] cyc = 0;
  logic [31:0] beat_cyc;
  logic [3:0]  frames [11][128];

  xfer_t obs_q[$], exp_q[$], obs_br_q[$], exp_br_q[$];
  int n_last, ovf_cnt, ferr_cnt, br_ovf_cnt, br_ferr_cnt, stall_viol, valid_viol;
  logic [31:0] ovf_cyc, ferr_cyc;
  logic        prev_stall;
  logic [15:0] prev_data;
  logic [6:0]  prev_idx;
  logic        prev_last;

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  ntt_in_receiver #(.BIT_REV(0)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_idx(coef_idx), .coef_last(coef_last), .frame_err(frame_err), .ovf_err(ovf_err)
  );

  ntt_in_receiver #(.BIT_REV(1)) dut_br (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .coef_valid(br_valid), .coef_ready(coef_ready), .coef_data(br_data),
    .coef_idx(br_idx), .coef_last(br_last), .frame_err(br_ferr), .ovf_err(br_oerr)
  );

  // Observer: records transfers and pulses, flags zeroing and stall-stability violations.
  always @(negedge clk1) begin
    xfer_t t;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (!coef_valid && (coef_data != 16'd0 || coef_idx != 7'd0 || coef_last)) valid_viol++;
      if (prev_stall && (coef_valid !== 1'b1 || coef_data !== prev_data ||
                         coef_idx !== prev_idx || coef_last !== prev_last)) stall_viol++;
      prev_stall = coef_valid & ~coef_ready;
      prev_data  = coef_data;
      prev_idx   = coef_idx;
      prev_last  = coef_last;
      if (coef_valid && coef_ready) begin
        t.idx = coef_idx; t.data = coef_data; t.last = coef_last; t.cyc = cyc;
        obs_q.push_back(t);
        if (coef_last) n_last++;
      end
      if (br_valid && coef_ready) begin
        t.idx = br_idx; t.data = br_data; t.last = br_last; t.cyc = cyc;
        obs_br_q.push_back(t);
      end
      if (ovf_err) begin ovf_cnt++; ovf_cyc = cyc; end
      if (frame_err) begin ferr_cnt++; ferr_cyc = cyc; end
      if (br_oerr) br_ovf_cnt++;
      if (br_ferr) br_ferr_cnt++;
    end
  end

  function automatic int rev7(input int k);
    int r = 0;
    for (int b = 0; b < 7; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  // Reference: a frame drains as coefficients 0..127 (or their bit-reversed indices) in order.
  task automatic push_exp(input int f);
    xfer_t t;
    for (int k = 0; k < 128; k++) begin
      t.idx = 7'(k); t.data = {12'd0, frames[f][k]}; t.last = (k == 127); t.cyc = 0;
      exp_q.push_back(t);
      t.idx = 7'(rev7(k)); t.data = {12'd0, frames[f][rev7(k)]};
      exp_br_q.push_back(t);
    end
  endtask

  task automatic clear_obs;
    obs_q.delete(); exp_q.delete(); obs_br_q.delete(); exp_br_q.delete();
    n_last = 0; ovf_cnt = 0; ferr_cnt = 0; br_ovf_cnt = 0; br_ferr_cnt = 0;
    stall_viol = 0; valid_viol = 0;
  endtask

  task automatic send_beats(input int f, input int first, input int n);
    for (int b = first; b < first + n; b++) begin
      in_valid = 1'b1;
      for (int j = 0; j < 8; j++) in_data[4*j +: 4] = frames[f][8*b + j];
      @(posedge clk1); #1;
      beat_cyc = cyc;
    end
  endtask

  task automatic wait_xfers(input int n, input int budget, input bit br, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if ((br ? obs_br_q.size() : obs_q.size()) >= n) begin ok = 1'b1; break; end
      @(negedge clk1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; coef_ready = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    checks++; if (coef_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", coef_valid); end
    checks++; if (coef_data !== 16'd0) begin errors++; $display("FAIL reset_data got %0h want 0", coef_data); end
    checks++; if (coef_idx !== 7'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", coef_idx); end
    checks++; if (coef_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", coef_last); end
    checks++; if (frame_err !== 1'b0 || ovf_err !== 1'b0) begin errors++; $display("FAIL reset_errs got %b%b want 00", frame_err, ovf_err); end
    rst_n = 1'b1;
    @(posedge clk1); #1;
    checks++; if (coef_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %b want 0", coef_valid); end
  endtask

  task automatic test_single_frame;
    bit ok;
    logic [31:0] last_beat;
    clear_obs(); coef_ready = 1'b1;
    push_exp(0);
    send_beats(0, 0, 16);
    last_beat = beat_cyc; in_valid = 1'b0;
    checks++; if (coef_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", coef_valid); end
    @(posedge clk1); #1;
    checks++; if (coef_valid !== 1'b1 || coef_idx !== 7'd0) begin errors++; $display("FAIL single_first got valid=%b idx=%0d want 1/0", coef_valid, coef_idx); end
    wait_xfers(128, 400, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d xfers want 128", obs_q.size()); end
    repeat (5) @(posedge clk1); #1;
    checks++; if (obs_q.size() != 128) begin errors++; $display("FAIL single_count got %0d want 128", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].idx !== exp_q[i].idx || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL single_coef[%0d] got idx=%0d data=%0d last=%b want idx=%0d data=%0d last=%b",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
      end
    end
    if (obs_q.size() == 128) begin
      checks++; if (obs_q[0].cyc !== last_beat + 1) begin errors++; $display("FAIL single_latency got %0d want %0d", obs_q[0].cyc, last_beat + 1); end
      checks++; if (obs_q[127].cyc - obs_q[0].cyc !== 32'd127) begin errors++; $display("FAIL single_drain_time got %0d want 127", obs_q[127].cyc - obs_q[0].cyc); end
    end
    checks++; if (n_last != 1 || valid_viol != 0) begin errors++; $display("FAIL single_last_zero got last=%0d viol=%0d want 1/0", n_last, valid_viol); end
  endtask

  task automatic test_bit_rev;
    bit ok;
    clear_obs(); coef_ready = 1'b1;
    push_exp(0);
    send_beats(0, 0, 16);
    in_valid = 1'b0;
    wait_xfers(128, 400, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bitrev_timeout got %0d xfers want 128", obs_br_q.size()); end
    repeat (5) @(posedge clk1); #1;
    checks++; if (obs_br_q.size() != 128) begin errors++; $display("FAIL bitrev_count got %0d want 128", obs_br_q.size()); end
    for (int i = 0; i < exp_br_q.size() && i < obs_br_q.size(); i++) begin
      checks++;
      if (obs_br_q[i].idx !== exp_br_q[i].idx || obs_br_q[i].data !== exp_br_q[i].data || obs_br_q[i].last !== exp_br_q[i].last) begin
        errors++;
        $display("FAIL bitrev_coef[%0d] got idx=%0d data=%0d last=%b want idx=%0d data=%0d last=%b",
                 i, obs_br_q[i].idx, obs_br_q[i].data, obs_br_q[i].last, exp_br_q[i].idx, exp_br_q[i].data, exp_br_q[i].last);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok, done, got;
    clear_obs(); done = 1'b0;
    push_exp(1); push_exp(2); push_exp(3);
    fork
      begin
        send_beats(1, 0, 16);
        send_beats(2, 0, 16);
        in_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 2000; c++) begin
          @(negedge clk1);
          if (n_last >= 1) begin got = 1'b1; break; end
        end
        checks++; if (!got) begin errors++; $display("FAIL b2b_first_drain got %0d lasts want 1", n_last); end
        send_beats(3, 0, 16);
        in_valid = 1'b0;
        wait_xfers(384, 3000, 1'b0, ok);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk1); #1;
          coef_ready = 1'($urandom_range(0, 1));
        end
        coef_ready = 1'b1;
      end
    join
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got %0d xfers want 384", obs_q.size()); end
    repeat (5) @(posedge clk1); #1;
    checks++; if (obs_q.size() != 384) begin errors++; $display("FAIL b2b_count got %0d want 384", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].idx !== exp_q[i].idx || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL b2b_coef[%0d] got idx=%0d data=%0d last=%b want idx=%0d data=%0d last=%b",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
      end
    end
    checks++; if (ovf_cnt != 0 || ferr_cnt != 0) begin errors++; $display("FAIL b2b_errs got ovf=%0d ferr=%0d want 0/0", ovf_cnt, ferr_cnt); end
    checks++; if (stall_viol != 0 || valid_viol != 0) begin errors++; $display("FAIL b2b_stable got stall=%0d zero=%0d want 0/0", stall_viol, valid_viol); end
    checks++; if (n_last != 3) begin errors++; $display("FAIL b2b_lasts got %0d want 3", n_last); end
  endtask

  task automatic test_overrun;
    bit ok;
    logic [31:0] drop_cyc;
    clear_obs(); coef_ready = 1'b0;
    push_exp(4); push_exp(5);
    send_beats(4, 0, 16);
    send_beats(5, 0, 16);
    send_beats(6, 0, 1);
    drop_cyc = beat_cyc;
    send_beats(6, 1, 15);
    in_valid = 1'b0;
    repeat (10) @(posedge clk1); #1;
    checks++; if (coef_valid !== 1'b1 || coef_idx !== 7'd0) begin errors++; $display("FAIL ovf_hold got valid=%b idx=%0d want 1/0", coef_valid, coef_idx); end
    coef_ready = 1'b1;
    wait_xfers(256, 600, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got %0d xfers want 256", obs_q.size()); end
    repeat (40) @(posedge clk1); #1;
    checks++; if (obs_q.size() != 256) begin errors++; $display("FAIL ovf_count got %0d want 256", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].idx !== exp_q[i].idx || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL ovf_coef[%0d] got idx=%0d data=%0d last=%b want idx=%0d data=%0d last=%b",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
      end
    end
    checks++; if (ovf_cnt != 1 || br_ovf_cnt != 1) begin errors++; $display("FAIL ovf_pulses got %0d/%0d want 1/1", ovf_cnt, br_ovf_cnt); end
    checks++; if (ovf_cyc !== drop_cyc) begin errors++; $display("FAIL ovf_timing got cycle %0d want %0d", ovf_cyc, drop_cyc); end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL ovf_no_ferr got %0d want 0", ferr_cnt); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL ovf_stable got %0d want 0", stall_viol); end
  endtask

  task automatic test_short_frame;
    bit ok;
    logic [31:0] short_cyc;
    clear_obs(); coef_ready = 1'b1;
    push_exp(8);
    send_beats(7, 0, 7);
    short_cyc = beat_cyc;
    in_valid = 1'b0;
    repeat (3) @(posedge clk1); #1;
    send_beats(8, 0, 16);
    in_valid = 1'b0;
    wait_xfers(128, 400, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL short_timeout got %0d xfers want 128", obs_q.size()); end
    repeat (20) @(posedge clk1); #1;
    checks++; if (obs_q.size() != 128) begin errors++; $display("FAIL short_count got %0d want 128", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].idx !== exp_q[i].idx || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL short_coef[%0d] got idx=%0d data=%0d last=%b want idx=%0d data=%0d last=%b",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
      end
    end
    checks++; if (ferr_cnt != 1 || br_ferr_cnt != 1) begin errors++; $display("FAIL short_pulses got %0d/%0d want 1/1", ferr_cnt, br_ferr_cnt); end
    checks++; if (ferr_cyc !== short_cyc + 1) begin errors++; $display("FAIL short_timing got cycle %0d want %0d", ferr_cyc, short_cyc + 1); end
    checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL short_no_ovf got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_reset_mid_drain;
    bit ok, found;
    clear_obs(); coef_ready = 1'b1;
    send_beats(9, 0, 16);
    in_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk1);
      if (coef_valid && coef_idx == 7'd50) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach got idx=%0d want 50", coef_idx); end
    rst_n = 1'b0;
    @(posedge clk1); #1;
    checks++;
    if (coef_valid !== 1'b0 || coef_data !== 16'd0 || coef_idx !== 7'd0 || coef_last !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs got valid=%b data=%0d idx=%0d last=%b want 0/0/0/0", coef_valid, coef_data, coef_idx, coef_last);
    end
    rst_n = 1'b1;
    @(posedge clk1); #1;
    clear_obs();
    push_exp(10);
    send_beats(10, 0, 16);
    in_valid = 1'b0;
    wait_xfers(128, 400, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got %0d xfers want 128", obs_q.size()); end
    repeat (10) @(posedge clk1); #1;
    checks++; if (obs_q.size() != 128) begin errors++; $display("FAIL rstmid_count got %0d want 128", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].idx !== exp_q[i].idx || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL rstmid_coef[%0d] got idx=%0d data=%0d last=%b want idx=%0d data=%0d last=%b",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
      end
    end
    checks++; if (ferr_cnt != 0 || ovf_cnt != 0) begin errors++; $display("FAIL rstmid_errs got ferr=%0d ovf=%0d want 0/0", ferr_cnt, ovf_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) frames[0][i] = 4'(i % 16);
    for (int f = 1; f < 11; f++)
      for (int i = 0; i < 128; i++) frames[f][i] = 4'($urandom_range(0, 15));
    clear_obs();
    prev_stall = 1'b0;
    test_reset();
    test_single_frame();
    test_bit_rev();
    test_back_to_back();
    test_overrun();
    test_short_frame();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
